// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - Shared Ascon constants, widths, FSM state type and rotate helper.
package ascon_pkg;

  localparam int STATE_W = 320;
  localparam int RATE_W  = 128;
  localparam int KEY_W   = 128;

  localparam logic [63:0]     ASCON_IV  = 64'h80800c0800000000;
  localparam logic [RATE_W-1:0] ASCON_PAD = {8'h80, 120'h0};

  localparam logic [3:0] ROUNDS_A = 4'd12;
  localparam logic [3:0] ROUNDS_B = 4'd8;

  // Entry [i] is the constant of round i of the 12-round permutation.
  localparam logic [11:0][7:0] ASCON_RC = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    AD    = 3'd2,
    ADPAD = 3'd3,
    CT    = 3'd4,
    FINAL = 3'd5,
    DONE  = 3'd6
  } state_e;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - One combinational Ascon permutation round (constant, S-box, linear layer).
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [3:0]         rc_idx_i,
  output logic [STATE_W-1:0] state_o
);

  logic [7:0]  rc;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Indices past 11 only occur while the core idles; they add no constant.
  assign rc = (rc_idx_i < 4'd12) ? ASCON_RC[rc_idx_i] : 8'h00;

  always_comb begin
    x0 = state_i[319:256];
    x1 = state_i[255:192];
    x2 = state_i[191:128] ^ {56'h0, rc};
    x3 = state_i[127:64];
    x4 = state_i[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);

    state_o = {x0, x1, x2, x3, x4};
  end

endmodule

// File: rtl/ascon_decrypt128a.sv
// rtl/ascon_decrypt128a.sv - Ascon-128a single-block decrypt core, one round per cycle.
// Optional ASCON_TAG_MASK_EN: P reads zero whenever tag_ok is low.
module ascon_decrypt128a
  import ascon_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [127:0] A,
  input  logic [127:0] C,
  input  logic [127:0] T,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] P,
  output logic         tag_ok,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e fsm_q, fsm_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [STATE_W-1:0] rnd_s, dom_s;
  logic [KEY_W-1:0]   sk_q, sk_d;
  logic [RATE_W-1:0]  a_q, a_d, c_q, c_d, t_q, t_d;
  logic [RATE_W-1:0]  p_q, p_d;
  logic               tag_ok_q, tag_ok_d;
  logic               last_round;

  ascon_round u_round (
    .state_i  (s_q),
    .rc_idx_i (ROUNDS_A - cnt_q),
    .state_o  (rnd_s)
  );

  assign last_round = (cnt_q == 4'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q    <= IDLE;
      cnt_q    <= 4'd0;
      s_q      <= '0;
      sk_q     <= '0;
      a_q      <= '0;
      c_q      <= '0;
      t_q      <= '0;
      p_q      <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      sk_q     <= sk_d;
      a_q      <= a_d;
      c_q      <= c_d;
      t_q      <= t_d;
      p_q      <= p_d;
      tag_ok_q <= tag_ok_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    sk_d     = sk_q;
    a_d      = a_q;
    c_d      = c_q;
    t_d      = t_q;
    p_d      = p_q;
    tag_ok_d = tag_ok_q;
    dom_s    = rnd_s ^ {{(STATE_W-1){1'b0}}, 1'b1};

    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          s_d   = {ASCON_IV, SK, N};
          sk_d  = SK;
          a_d   = A;
          c_d   = C;
          t_d   = T;
          cnt_d = ROUNDS_A;
          fsm_d = INIT;
        end
      end
      INIT: begin
        s_d   = rnd_s;
        cnt_d = cnt_q - 4'd1;
        if (last_round) begin
          s_d   = rnd_s ^ {192'h0, sk_q} ^ {a_q, 192'h0};
          cnt_d = ROUNDS_B;
          fsm_d = AD;
        end
      end
      AD: begin
        s_d   = rnd_s;
        cnt_d = cnt_q - 4'd1;
        if (last_round) begin
          s_d   = rnd_s ^ {ASCON_PAD, 192'h0};
          cnt_d = ROUNDS_B;
          fsm_d = ADPAD;
        end
      end
      ADPAD: begin
        s_d   = rnd_s;
        cnt_d = cnt_q - 4'd1;
        if (last_round) begin
          // Domain separation first, then the rate is replaced by the ciphertext.
          p_d   = dom_s[319:192] ^ c_q;
          s_d   = {c_q, dom_s[191:0]};
          cnt_d = ROUNDS_B;
          fsm_d = CT;
        end
      end
      CT: begin
        s_d   = rnd_s;
        cnt_d = cnt_q - 4'd1;
        if (last_round) begin
          s_d   = rnd_s ^ {ASCON_PAD, 192'h0} ^ {128'h0, sk_q, 64'h0};
          cnt_d = ROUNDS_A;
          fsm_d = FINAL;
        end
      end
      FINAL: begin
        s_d   = rnd_s;
        cnt_d = cnt_q - 4'd1;
        if (last_round) begin
          tag_ok_d = ((rnd_s[127:0] ^ sk_q) == t_q);
          fsm_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign tag_ok    = tag_ok_q;

`ifdef ASCON_TAG_MASK_EN
  assign P = tag_ok_q ? p_q : '0;
`else
  assign P = p_q;
`endif

endmodule

// File: tb/tb_ascon_decrypt128a.sv
// tb/tb_ascon_decrypt128a.sv - Self-checking bench for the Ascon-128a decrypt core.
module tb_ascon_decrypt128a;

  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] SK, N, A, C, T;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] P;
  logic         tag_ok;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] A0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] P0 = 128'h0123456789ABCDEFFEDCBA9876543210;

  // Ascon 5-bit S-box table, entry i at bits [5i+4:5i], input x0 is the MSB.
  localparam logic [159:0] SBOX_LUT = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };

  logic [127:0] C0, T0;

  ascon_decrypt128a dut (
    .CLK       (CLK),
    .RST       (RST),
    .SK        (SK),
    .N         (N),
    .A         (A),
    .C         (C),
    .T         (T),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .tag_ok    (tag_ok),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] m_rot(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    logic [7:0]  rc;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    rc   = 8'hf0 - 8'(15 * r);
    x[2] = x[2] ^ {56'h0, rc};
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = SBOX_LUT[int'(col)*5 +: 5];
      for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
    end
    y[0] = y[0] ^ m_rot(y[0], 19) ^ m_rot(y[0], 28);
    y[1] = y[1] ^ m_rot(y[1], 61) ^ m_rot(y[1], 39);
    y[2] = y[2] ^ m_rot(y[2], 1)  ^ m_rot(y[2], 6);
    y[3] = y[3] ^ m_rot(y[3], 10) ^ m_rot(y[3], 17);
    y[4] = y[4] ^ m_rot(y[4], 7)  ^ m_rot(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
    logic [319:0] v;
    v = s;
    for (int r = 12 - nr; r < 12; r++) v = m_round(v, r);
    return v;
  endfunction

  // Reference encryption with the same phase schedule; returns {C, T}.
  function automatic logic [255:0] m_encrypt(input logic [127:0] k, input logic [127:0] n,
                                             input logic [127:0] a, input logic [127:0] p);
    logic [319:0] s;
    logic [127:0] c;
    s = m_perm({64'h80800c0800000000, k, n}, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:192] = s[319:192] ^ a;
    s = m_perm(s, 8);
    s[319:192] = s[319:192] ^ {8'h80, 120'h0};
    s = m_perm(s, 8);
    s[0] = ~s[0];
    c = s[319:192] ^ p;
    s[319:192] = c;
    s = m_perm(s, 8);
    s[319:192] = s[319:192] ^ {8'h80, 120'h0};
    s[191:64]  = s[191:64] ^ k;
    s = m_perm(s, 12);
    return {c, s[127:0] ^ k};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                         input logic [127:0] c, input logic [127:0] t,
                         output int lat, output logic [127:0] p, output logic ok, output int busy_rdy);
    SK = k; N = n; A = a; C = c; T = t;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat      = 1;
    busy_rdy = 0;
    while (out_valid !== 1'b1 && lat < 120) begin
      if (in_ready === 1'b1) busy_rdy++;
      @(posedge CLK); #1;
      lat++;
    end
    p  = P;
    ok = tag_ok;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (P !== 128'h0) $display("FAIL reset_p got=%h exp=0", P); else passes++;
    checks++; if (tag_ok !== 1'b0) $display("FAIL reset_tag_ok got=%b exp=0", tag_ok); else passes++;
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_nominal();
    int lat, busy; logic [127:0] p; logic ok;
    run_job(K0, K0, A0, C0, T0, lat, p, ok, busy);
    checks++; if (lat !== 49) $display("FAIL nominal_latency got=%0d exp=49", lat); else passes++;
    checks++; if (p !== P0) $display("FAIL nominal_p got=%h exp=%h", p, P0); else passes++;
    checks++; if (ok !== 1'b1) $display("FAIL nominal_tag_ok got=%b exp=1", ok); else passes++;
    checks++; if (busy !== 0) $display("FAIL nominal_busy_in_ready got=%0d exp=0", busy); else passes++;
    @(posedge CLK); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL nominal_return_idle got=%b%b exp=01", out_valid, in_ready); else passes++;
  endtask

  task automatic test_bad_tag();
    int lat, busy; logic [127:0] p, exp_p; logic ok;
`ifdef ASCON_TAG_MASK_EN
    exp_p = 128'h0;
`else
    exp_p = P0;
`endif
    run_job(K0, K0, A0, C0, T0 ^ 128'h1, lat, p, ok, busy);
    checks++; if (ok !== 1'b0) $display("FAIL badtag_tag_ok got=%b exp=0", ok); else passes++;
    checks++; if (p !== exp_p) $display("FAIL badtag_p got=%h exp=%h", p, exp_p); else passes++;
    checks++; if (lat !== 49) $display("FAIL badtag_latency got=%0d exp=49", lat); else passes++;
  endtask

  task automatic test_bad_ct();
    int lat, busy; logic [127:0] p, flip, exp_p; logic ok;
    flip = {1'b1, 127'h0};
`ifdef ASCON_TAG_MASK_EN
    exp_p = 128'h0;
`else
    exp_p = P0 ^ flip;
`endif
    run_job(K0, K0, A0, C0 ^ flip, T0, lat, p, ok, busy);
    checks++; if (ok !== 1'b0) $display("FAIL badct_tag_ok got=%b exp=0", ok); else passes++;
    checks++; if (p !== exp_p) $display("FAIL badct_p got=%h exp=%h", p, exp_p); else passes++;
  endtask

  task automatic test_stall();
    int wait_n, bad_p, bad_ok, bad_v, bad_r, late;
    SK = K0; N = K0; A = A0; C = C0; T = T0;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_n = 0;
    while (out_valid !== 1'b1 && wait_n < 120) begin @(posedge CLK); #1; wait_n++; end
    checks++; if (out_valid !== 1'b1) $display("FAIL stall_reach_done got=%b exp=1", out_valid); else passes++;
    bad_p = 0; bad_ok = 0; bad_v = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      SK = rnd128(); N = rnd128(); A = rnd128(); C = rnd128(); T = rnd128();
      in_valid = 1'b1;
      if (P !== P0) bad_p++;
      if (tag_ok !== 1'b1) bad_ok++;
      if (out_valid !== 1'b1) bad_v++;
      if (in_ready !== 1'b0) bad_r++;
      @(posedge CLK); #1;
    end
    checks++; if (bad_p !== 0) $display("FAIL stall_p_stable got=%0d bad cycles exp=0", bad_p); else passes++;
    checks++; if (bad_ok !== 0) $display("FAIL stall_tag_ok got=%0d bad cycles exp=0", bad_ok); else passes++;
    checks++; if (bad_v !== 0) $display("FAIL stall_out_valid got=%0d bad cycles exp=0", bad_v); else passes++;
    checks++; if (bad_r !== 0) $display("FAIL stall_in_ready got=%0d bad cycles exp=0", bad_r); else passes++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL stall_release got=%b%b exp=10", in_ready, out_valid); else passes++;
    late = 0;
    repeat (60) begin @(posedge CLK); #1; if (out_valid === 1'b1) late++; end
    checks++; if (late !== 0) $display("FAIL stall_no_accept got=%0d valid cycles exp=0", late); else passes++;
  endtask

  task automatic test_reset_mid();
    int seen, lat, busy; logic [127:0] p; logic ok;
    SK = K0; N = K0; A = A0; C = C0; T = T0;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++; if (P !== 128'h0 || tag_ok !== 1'b0)
      $display("FAIL rstmid_outputs_cleared got=%h/%b exp=0/0", P, tag_ok); else passes++;
    seen = 0;
    repeat (70) begin @(posedge CLK); #1; if (out_valid === 1'b1) seen++; end
    checks++; if (seen !== 0) $display("FAIL rstmid_no_output got=%0d valid cycles exp=0", seen); else passes++;
    run_job(K0, K0, A0, C0, T0, lat, p, ok, busy);
    checks++; if (p !== P0 || ok !== 1'b1)
      $display("FAIL rstmid_next_job got=%h/%b exp=%h/1", p, ok, P0); else passes++;
  endtask

  task automatic test_reset_priority();
    int seen;
    SK = K0; N = K0; A = A0; C = C0; T = T0;
    in_valid = 1'b1;
    RST      = 1'b1;
    @(posedge CLK); #1;
    RST      = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstprio_in_ready got=%b exp=1", in_ready); else passes++;
    seen = 0;
    repeat (60) begin @(posedge CLK); #1; if (out_valid === 1'b1) seen++; end
    checks++; if (seen !== 0) $display("FAIL rstprio_no_job got=%0d valid cycles exp=0", seen); else passes++;
  endtask

  task automatic test_back_to_back();
    localparam int NV = 8;
    logic [127:0] vk [NV], vn [NV], va [NV], vp [NV], vc [NV], vt [NV];
    logic [255:0] ct;
    int nacc, nres, last_acc, bad_gap;
    logic acc;
    for (int i = 0; i < NV; i++) begin
      vk[i] = rnd128(); vn[i] = rnd128(); va[i] = rnd128(); vp[i] = rnd128();
      ct = m_encrypt(vk[i], vn[i], va[i], vp[i]);
      vc[i] = ct[255:128];
      vt[i] = ct[127:0];
    end
    out_ready = 1'b1;
    SK = vk[0]; N = vn[0]; A = va[0]; C = vc[0]; T = vt[0];
    in_valid = 1'b1;
    nacc = 0; nres = 0; last_acc = 0; bad_gap = 0;
    for (int k = 0; k < NV * 50 + 200 && nres < NV; k++) begin
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++; if (P !== vp[nres]) $display("FAIL b2b_p[%0d] got=%h exp=%h", nres, P, vp[nres]); else passes++;
        checks++; if (tag_ok !== 1'b1) $display("FAIL b2b_tag_ok[%0d] got=%b exp=1", nres, tag_ok); else passes++;
        nres++;
      end
      @(posedge CLK); #1;
      if (acc) begin
        if (nacc > 0 && (cyc - last_acc) != 50) bad_gap++;
        last_acc = cyc;
        nacc++;
        if (nacc < NV) begin
          SK = vk[nacc]; N = vn[nacc]; A = va[nacc]; C = vc[nacc]; T = vt[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (nres !== NV) $display("FAIL b2b_results got=%0d exp=%0d", nres, NV); else passes++;
    checks++; if (bad_gap !== 0 || nacc !== NV)
      $display("FAIL b2b_spacing got=%0d bad gaps, %0d accepts exp=0,%0d", bad_gap, nacc, NV); else passes++;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [255:0] ct;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    SK = '0; N = '0; A = '0; C = '0; T = '0;
    ct = m_encrypt(K0, K0, A0, P0);
    C0 = ct[255:128];
    T0 = ct[127:0];
    test_reset();
    test_nominal();
    test_bad_tag();
    test_bad_ct();
    test_stall();
    test_reset_mid();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ascon_decrypt128a.md
ASCON_DECRYPT128A -- requirements
Module: ascon_decrypt128a

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port SK, input, 128 bits: secret key, sampled on accept.
REQ-004 SHALL have port N, input, 128 bits: nonce, sampled on accept.
REQ-005 SHALL have port A, input, 128 bits: one full associated-data block, sampled on accept.
REQ-006 SHALL have port C, input, 128 bits: one full ciphertext block, sampled on accept.
REQ-007 SHALL have port T, input, 128 bits: received tag, sampled on accept.
REQ-008 SHALL have port in_valid, input, 1 bit: the SK/N/A/C/T job is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the core can accept a job.
REQ-010 SHALL have port P, output, 128 bits: recovered plaintext.
REQ-011 SHALL have port tag_ok, output, 1 bit: the computed tag equals T.
REQ-012 SHALL have port out_valid, output, 1 bit: P and tag_ok are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-014 SHALL implement Ascon-128a decryption: 320-bit state, rate 128, 12 initialisation/finalisation rounds, 8 intermediate rounds, IV 0x80800c0800000000.
REQ-015 SHALL accept a job only when in_valid and in_ready are both high; all inputs are registered at that edge.
REQ-016 SHALL use FSM states IDLE, INIT, AD, ADPAD, CT, FINAL, DONE, with one permutation round per cycle.
REQ-017 IDLE->INIT on accept; state loaded as IV||SK||N, round counter loaded to 12.
REQ-018 INIT end: XOR 0^192||SK into the state; XOR A into S[0:127]; ->AD (8 rounds).
REQ-019 AD end: XOR the pad block 0x80||0^120 into S[0:127]; ->ADPAD (8 rounds).
REQ-020 ADPAD end: XOR domain bit 1 into the state LSB; P_reg = S[0:127]^C; S[0:127] = C; ->CT (8 rounds).
REQ-021 CT end: XOR 0x80||0^120 into S[0:127]; XOR 0^128||SK||0^64 into the state; ->FINAL (12 rounds).
REQ-022 FINAL end: computed tag = S[192:319]^SK; tag_ok_reg = (computed tag == T_reg); ->DONE.
REQ-023 Latency SHALL be fixed: out_valid rises exactly 49 cycles after the accept edge (48 rounds + 1 DONE-entry cycle).
REQ-024 In DONE: out_valid=1; P and tag_ok held stable until out_ready=1; then ->IDLE next edge.
REQ-025 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored and does not corrupt the job in flight.
REQ-026 With out_ready held high, back-to-back jobs SHALL sustain one job per 50 cycles.
REQ-027 The round counter SHALL be 4 bits and decrement to 0; the phase step occurs when the counter is 1 and the round completes.
REQ-028 The tag comparison SHALL be a full 128-bit equality; no partial match.

Reset
REQ-029 RST=1 at any edge SHALL force IDLE, out_valid=0, in_ready=1 (after release), P=0, tag_ok=0, state=0 and counter=0, aborting any job with no output.
REQ-030 RST asserted in the same cycle as in_valid SHALL take priority; no job is accepted.

Configuration
REQ-031 When ASCON_TAG_MASK_EN is defined, P SHALL read all-zero whenever tag_ok=0 (unverified plaintext is never released); when undefined, P always carries the decrypted value.

Structure
REQ-032 Package ascon_pkg SHALL hold: the IV constant, the 12 round constants, rate/state width localparams, the FSM state enum and the pad constant.
REQ-033 A single sub-module ascon_round (combinational: 320-bit state in, round-constant index in, 320-bit state out) SHALL be instantiated once and shared with the encrypt core.

Verification
REQ-034 SK=N=0x000102030405060708090A0B0C0D0E0F, A=0x00112233445566778899AABBCCDDEEFF, P0=0x0123456789ABCDEFFEDCBA9876543210 encrypted by the team's encrypt top to (C,T); feeding (SK,N,A,C,T) -> P=P0, tag_ok=1, out_valid exactly 49 cycles after accept.
REQ-035 Same vector with T bit 0 flipped -> tag_ok=0; P=P0 without the macro, P=0 with ASCON_TAG_MASK_EN.
REQ-036 Same vector with C bit 127 flipped -> tag_ok=0 and P bit 127 differs from P0.
REQ-037 out_ready held 0 for 20 cycles in DONE -> P/tag_ok stable, out_valid=1, in_ready=0 throughout; a new in_valid during that time is not accepted.
REQ-038 RST pulsed at round 30 of a job -> out_valid never rises for that job; a subsequent job returns the correct result.
REQ-039 10000 random vectors cross-checked against the encrypt top with out_ready=1 -> all tag_ok=1, with one accept every 50 cycles.
